// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage with miss wait and redirect drain handling.
// Optional IF_FETCH_PERF_CNT_EN adds a saturating miss_cycles counter port.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallF,
    input  logic        pcsrcE,
    input  logic [31:0] pctargetE,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic        ic_ready,
    input  logic [31:0] ic_rdata,
    output logic [31:0] instrF,
    output logic [31:0] PCF,
    output logic [31:0] PCplus4F,
    output logic        fetch_bubble,
`ifdef IF_FETCH_PERF_CNT_EN
    output logic [31:0] miss_cycles,
`endif
    output logic        fetch_busy
);
    typedef enum logic [1:0] {FETCH, MISS_WAIT, DRAIN} state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state, state_n;
    logic [31:0] pc, pc_n, pending, pending_n, tgt, adv;
    logic        deliver;

    assign tgt      = {pctargetE[31:2], 2'b00};
    assign adv      = pcsrcE ? tgt : stallF ? pc : pc + 32'd4;
    assign deliver  = ic_ready && state != DRAIN;
    assign ic_req   = !rst;
    assign ic_addr  = pc;
    assign PCF      = pc;
    assign PCplus4F = pc + 32'd4;
    assign instrF   = deliver ? ic_rdata : NOP;
    assign fetch_bubble = !deliver;
    // The first miss cycle is already waiting on the cache, so busy covers it too.
    assign fetch_busy   = state != FETCH || !ic_ready;

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        pending_n = pending;
        case (state)
            FETCH: begin
                if (ic_ready || pcsrcE) pc_n = adv;
                if (!ic_ready && !pcsrcE) state_n = MISS_WAIT;
            end
            MISS_WAIT: begin
                if (ic_ready) begin
                    pc_n    = adv;
                    state_n = FETCH;
                end else if (pcsrcE) begin
                    pending_n = tgt;
                    state_n   = DRAIN;
                end
            end
            DRAIN: begin
                if (pcsrcE) pending_n = tgt;
                if (ic_ready) begin
                    pc_n    = pcsrcE ? tgt : pending;
                    state_n = FETCH;
                end
            end
            default: state_n = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            pending <= 32'h0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            pending <= pending_n;
        end
    end

`ifdef IF_FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            miss_cycles <= 32'h0;
        else if (state != FETCH && miss_cycles != 32'hFFFF_FFFF)
            miss_cycles <= miss_cycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed stimulus with a queued scoreboard checked by a separate monitor.
module tb_if_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 0, rst = 1, stallF = 0, pcsrcE = 0, ic_ready = 0;
    logic [31:0] pctargetE = 0, ic_rdata = 0;
    logic        ic_req, fetch_bubble, fetch_busy;
    logic [31:0] ic_addr, instrF, PCF, PCplus4F;
`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] miss_cycles;
`endif

    if_fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .stallF(stallF), .pcsrcE(pcsrcE), .pctargetE(pctargetE),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_rdata(ic_rdata),
        .instrF(instrF), .PCF(PCF), .PCplus4F(PCplus4F), .fetch_bubble(fetch_bubble),
`ifdef IF_FETCH_PERF_CNT_EN
        .miss_cycles(miss_cycles),
`endif
        .fetch_busy(fetch_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        req;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        bubble;
        int          busy;
        longint      mc;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, id, act, req);
        end
    endtask

    // A busy/mc value of -1 means the field is not checked on that step.
    task automatic step(input int id, input logic r, input logic st, input logic ps,
                        input logic [31:0] tg, input logic rdy, input logic [31:0] rd,
                        input logic [31:0] epc, input logic ebub, input int ebusy, input longint emc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; stallF = st; pcsrcE = ps; pctargetE = tg; ic_ready = rdy; ic_rdata = rd;
        e.id = id; e.req = !r; e.pc = epc; e.bubble = ebub;
        e.instr = ebub ? NOP : rd; e.busy = ebusy; e.mc = emc;
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ic_req", e.id, {31'b0, ic_req}, {31'b0, e.req});
                chk("pcf", e.id, PCF, e.pc);
                chk("ic_addr", e.id, ic_addr, e.pc);
                chk("pcplus4", e.id, PCplus4F, e.pc + 32'd4);
                chk("bubble", e.id, {31'b0, fetch_bubble}, {31'b0, e.bubble});
                chk("instr", e.id, instrF, e.instr);
                if (e.busy >= 0) chk("busy", e.id, {31'b0, fetch_busy}, e.busy[31:0]);
`ifdef IF_FETCH_PERF_CNT_EN
                if (e.mc >= 0) chk("miss_cycles", e.id, miss_cycles, e.mc[31:0]);
`endif
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        //      id rst st ps target        rdy rdata         pc            bub busy mc
        step( 1, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, -1, -1);
        step( 2, 0, 0, 0, 32'h0,        1, 32'hA000_0000, 32'h0,       0,  0,  0);
        step( 3, 0, 0, 0, 32'h0,        1, 32'hA000_0001, 32'h4,       0,  0, -1);
        step( 4, 0, 0, 0, 32'h0,        1, 32'hA000_0002, 32'h8,       0,  0, -1);
        step( 5, 0, 0, 0, 32'h0,        1, 32'hA000_0003, 32'hC,       0,  0, -1);
        step( 6, 0, 0, 0, 32'h0,        0, 32'hDEAD_BEEF, 32'h10,      1,  1,  0);
        step( 7, 0, 0, 0, 32'h0,        0, 32'hDEAD_BEEF, 32'h10,      1,  1,  0);
        step( 8, 0, 0, 0, 32'h0,        0, 32'hDEAD_BEEF, 32'h10,      1,  1,  1);
        step( 9, 0, 0, 0, 32'h0,        0, 32'hDEAD_BEEF, 32'h10,      1,  1,  2);
        step(10, 0, 0, 0, 32'h0,        1, 32'hB000_0010, 32'h10,      0,  1,  3);
        step(11, 0, 0, 0, 32'h0,        1, 32'hB000_0014, 32'h14,      0,  0,  4);
        step(12, 0, 0, 0, 32'h0,        0, 32'h0,        32'h18,       1,  1,  4);
        step(13, 0, 0, 1, 32'h200,      0, 32'h0,        32'h18,       1,  1,  4);
        step(14, 0, 0, 0, 32'h0,        0, 32'h0,        32'h18,       1,  1,  5);
        step(15, 0, 0, 1, 32'h300,      0, 32'h0,        32'h18,       1,  1,  6);
        step(16, 0, 0, 0, 32'h0,        0, 32'h0,        32'h18,       1,  1,  7);
        step(17, 0, 0, 0, 32'h0,        1, 32'hC0DE_0018, 32'h18,      1,  1,  8);
        step(18, 0, 1, 1, 32'h41,       1, 32'hC000_0300, 32'h300,     0,  0,  9);
        step(19, 0, 1, 0, 32'h0,        1, 32'hC000_0040, 32'h40,      0,  0,  9);
        step(20, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'hC000_0041, 32'h40,     0,  0, -1);
        step(21, 0, 0, 0, 32'h0,        1, 32'hD000_FFFC, 32'hFFFF_FFFC, 0, 0, -1);
        step(22, 0, 0, 0, 32'h0,        1, 32'hD000_0000, 32'h0,       0,  0, -1);
        step(23, 0, 0, 1, 32'h80,       0, 32'h0,        32'h4,        1,  1,  9);
        step(24, 0, 0, 0, 32'h0,        1, 32'hE000_0080, 32'h80,      0,  0,  9);
        step(25, 0, 0, 0, 32'h0,        0, 32'h0,        32'h84,       1,  1,  9);
        step(26, 0, 0, 0, 32'h0,        0, 32'h0,        32'h84,       1,  1,  9);
        step(27, 1, 1, 1, 32'h500,      0, 32'h0,        32'h84,       1, -1, 10);
        step(28, 0, 0, 0, 32'h0,        1, 32'hF000_0000, 32'h0,       0,  0,  0);
        step(29, 0, 0, 0, 32'h0,        1, 32'hF000_0004, 32'h4,       0,  0,  0);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries never checked", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded on reset (bits [1:0] SHALL be 0).
REQ-002 SHALL have: clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have: stallF  input  1  hazard-unit hold; the PC does not advance.
REQ-005 SHALL have: pcsrcE  input  1  taken branch/jump redirect from execute.
REQ-006 SHALL have: pctargetE  input  32  redirect target; bits [1:0] ignored and treated as 00.
REQ-007 SHALL have: ic_req  output  1  instruction-cache request.
REQ-008 SHALL have: ic_addr  output  32  cache lookup address.
REQ-009 SHALL have: ic_ready  input  1  cache data valid, same cycle on hit, later on miss.
REQ-010 SHALL have: ic_rdata  input  32  cache instruction word.
REQ-011 SHALL have: instrF, PCF, PCplus4F  output  32 each  fetched word, its address, and address+4, feeding the IF/ID register.
REQ-012 SHALL have: fetch_bubble  output  1  current instrF is invalid; drives IF/ID Inst_flush.
REQ-013 SHALL have: fetch_busy  output  1  fetch is waiting on the cache; goes to the hazard unit.

Function
REQ-014 SHALL implement states FETCH, MISS_WAIT and DRAIN, and a 32-bit PC register plus a 32-bit pending-target register.
REQ-015 ic_req SHALL be 1 in every non-reset cycle, and ic_addr SHALL equal PCF.
REQ-016 PCplus4F SHALL equal PCF+4, modulo 2^32; 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-017 Combinationally, instrF SHALL equal ic_rdata when ic_ready=1 and the state is not DRAIN; otherwise it SHALL be 32'h0000_0013 (NOP) with fetch_bubble=1.
REQ-018 In FETCH with ic_ready=1: fetch_bubble=0, and next PC = pctargetE if pcsrcE=1, else PC if stallF=1, else PC+4.
REQ-019 In FETCH with ic_ready=0 and pcsrcE=0: fetch_bubble=1, the PC is held, and the block SHALL move to MISS_WAIT.
REQ-020 In FETCH with ic_ready=0 and pcsrcE=1: the PC SHALL load pctargetE and the state SHALL stay FETCH, because no refill is committed yet.
REQ-021 In MISS_WAIT: fetch_busy=1 and the PC and ic_addr are held; when ic_ready=1, the word is delivered (fetch_bubble=0), the PC advances per REQ-018 and the state returns to FETCH.
REQ-022 pcsrcE=1 in MISS_WAIT with ic_ready=0 SHALL latch pctargetE into the pending register and move to DRAIN, so the in-flight refill is not abandoned.
REQ-023 In DRAIN: fetch_busy=1 and fetch_bubble=1; a new pcsrcE=1 SHALL overwrite the pending register (last redirect wins); on ic_ready=1 the PC SHALL load the pending target and the state SHALL move to FETCH.
REQ-024 pcsrcE SHALL take priority over stallF in every state.
REQ-025 Latency: a hit delivers in the same cycle as the request; a miss delivers in the cycle ic_ready rises; a redirect takes effect on ic_addr 1 cycle after pcsrcE is sampled (after the drain completes, in DRAIN).

Reset
REQ-026 rst=1 SHALL force PCF=RESET_PC, state=FETCH, pending=0 and ic_req=0, overriding all other inputs, including in mid-miss or mid-drain.
REQ-027 In the first cycle after reset, ic_addr SHALL be RESET_PC with ic_req=1.

Configuration
REQ-028 With macro IF_FETCH_PERF_CNT_EN defined, the block SHALL add output miss_cycles (32 bits).
REQ-029 miss_cycles SHALL increment in each MISS_WAIT or DRAIN cycle, saturate at 32'hFFFF_FFFF, and be cleared by rst.
REQ-030 Without IF_FETCH_PERF_CNT_EN, the port and counter SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-031 Reset then ic_ready=1 for 3 cycles -> PCF 0x0, 0x4, 0x8; fetch_bubble=0 throughout; instrF=ic_rdata.
REQ-032 Miss at PC 0x10 with ic_ready low for 4 cycles -> fetch_busy=1 and instrF=0x00000013 for 4 cycles; PC held at 0x10; on ready, PC goes to 0x14.
REQ-033 Redirect in MISS_WAIT, first pcsrcE=1 with target 0x200, then 0x300 two cycles later, ready after 5 cycles -> ic_addr stays on the old PC until ready; next ic_addr=0x300; no word delivered during DRAIN.
REQ-034 stallF=1 and pcsrcE=1 in the same FETCH cycle with target 0x41 -> next PCF=0x40.
REQ-035 PC=0xFFFF_FFFC on a hit -> next PCF=0x0 and PCplus4F wraps correctly.
REQ-036 rst asserted mid-miss -> next cycle PCF=RESET_PC, state FETCH, fetch_busy=0; with IF_FETCH_PERF_CNT_EN defined, miss_cycles=0.
